// File: rtl/reg_bank_rd.sv
// ---------------------------------------------------------------------------
// reg_bank_rd
//
// 32-entry register bank for the multicycle CPU. It has one write port, which
// is fed by the write-register selector (rt / sp / ra / rd). It has two read
// ports, which load the A and B operand latches.
//
// A read is registered. The request (rd_req, ReadReg1, ReadReg2) is captured
// on a rising edge, and the operands appear on A_out / B_out with rd_valid
// asserted for that one following cycle. When the write port targets a
// requested register in the same cycle, the new write data is forwarded into
// the latched operand. rd_hit_bypass flags that case.
//
// Ports
//   clk            in   1       system clock, rising edge
//   reset          in   1       asynchronous active-low reset
//   RegWrite       in   1       write enable
//   WriteReg       in   ADDR_W  write index
//   WriteData      in   DATA_W  write data
//   rd_req         in   1       read request, captures ReadReg1/ReadReg2
//   ReadReg1       in   ADDR_W  rs index
//   ReadReg2       in   ADDR_W  rt index
//   A_out          out  DATA_W  latched operand for ReadReg1
//   B_out          out  DATA_W  latched operand for ReadReg2
//   rd_valid       out  1       one-cycle pulse per accepted rd_req
//   rd_hit_bypass  out  1       with rd_valid: an operand came from the bypass
// ---------------------------------------------------------------------------
module reg_bank_rd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 227,
    parameter int RA_IDX   = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    output logic              rd_valid,
    output logic              rd_hit_bypass
);

    localparam int DEPTH = 1 << ADDR_W;

    // Power-on contents. Only the stack pointer has a non-zero start value.
    // The return-address register starts at zero like the general entries.
    function automatic logic [DATA_W-1:0] reset_value(input int idx);
        if (idx == SP_IDX) begin
            return DATA_W'(SP_RESET);
        end else if (idx == RA_IDX) begin
            return '0;
        end else begin
            return '0;
        end
    endfunction

    logic [DATA_W-1:0] regs [DEPTH];

    logic              wr_en;
    logic              byp1;
    logic              byp2;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;

    // ------------------------------------------------------------------
    // Operand selection for the values about to be latched.
    // Index 0 is excluded from wr_en. A write to r0 therefore never updates
    // the array and is never reported as a bypass.
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default at the top so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        wr_en = 1'b0;
        byp1  = 1'b0;
        byp2  = 1'b0;
        val1  = '0;
        val2  = '0;

        wr_en = RegWrite && (WriteReg != '0);
        byp1  = wr_en && (WriteReg == ReadReg1);
        byp2  = wr_en && (WriteReg == ReadReg2);

        if (ReadReg1 == '0) begin
            val1 = '0;
        end else if (byp1) begin
            val1 = WriteData;
        end else begin
            val1 = regs[ReadReg1];
        end

        if (ReadReg2 == '0) begin
            val2 = '0;
        end else if (byp2) begin
            val2 = WriteData;
        end else begin
            val2 = regs[ReadReg2];
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------
    // NOTE: the array is built from flops with a reset, not from a RAM macro.
    // The stack pointer must come out of reset holding SP_RESET, and every
    // other entry must read zero.
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, so a same-edge read and write cannot race.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= reset_value(i);
            end
        end else if (wr_en) begin
            regs[WriteReg] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Operand latches and status flags.
    // When no request is made, the operands keep their last value, and the
    // valid and bypass flags drop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A_out         <= '0;
            B_out         <= '0;
            rd_valid      <= 1'b0;
            rd_hit_bypass <= 1'b0;
        end else if (rd_req) begin
            A_out         <= val1;
            B_out         <= val2;
            rd_valid      <= 1'b1;
            rd_hit_bypass <= byp1 || byp2;
        end else begin
            rd_valid      <= 1'b0;
            rd_hit_bypass <= 1'b0;
        end
    end

endmodule

// File: doc/reg_bank_rd.md
Name: reg_bank_rd

Overview:
- 32-entry register bank for the multicycle CPU.
- Takes the write address produced by the write-register selector (rt / sp / ra / rd).
- Provides the two operand-read ports that feed the A and B operand latches.
- Reads are registered: a request is issued in one cycle and operands appear, with a valid flag, on the next edge.
- A same-cycle write to a requested register is bypassed into the latched operand.

Parameters:
- DATA_W, 32, register and bus data width
- ADDR_W, 5, register index width (2^ADDR_W entries)
- SP_IDX, 29, stack pointer register index
- SP_RESET, 227, reset value of the stack pointer register
- RA_IDX, 31, return address register index (reset 0; named for test reference only)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- RegWrite  in  1  write enable
- WriteReg  in  ADDR_W  write index from the write-register selector
- WriteData  in  DATA_W  write data
- rd_req  in  1  read request; captures ReadReg1/ReadReg2 this edge
- ReadReg1  in  ADDR_W  rs index
- ReadReg2  in  ADDR_W  rt index
- A_out  out  DATA_W  latched operand for ReadReg1
- B_out  out  DATA_W  latched operand for ReadReg2
- rd_valid  out  1  high for exactly one cycle after each accepted rd_req
- rd_hit_bypass  out  1  high with rd_valid when either operand came from the bypass path

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - all entries 0 except entry SP_IDX = SP_RESET
  - A_out = 0, B_out = 0, rd_valid = 0, rd_hit_bypass = 0
- Reset release: takes effect at the next clk edge; no operations are lost or replayed.
- Write: on the rising edge with RegWrite=1 and WriteReg≠0, entry[WriteReg] <= WriteData.
  - Writes to index 0 are dropped; entry 0 always reads 0.
  - Writes to SP_IDX or RA_IDX behave as any other entry.
- Read, latency 1:
  - On the edge with rd_req=1, A_out <= value(ReadReg1), B_out <= value(ReadReg2), rd_valid <= 1.
  - On an edge with rd_req=0, rd_valid <= 0, rd_hit_bypass <= 0, and A_out/B_out hold their previous values.
- value(i):
  - 0 if i=0
  - else WriteData if RegWrite=1 and WriteReg=i in the same cycle (bypass, new data wins)
  - else entry[i]
- rd_hit_bypass <= rd_req and (bypass taken for port 1 or port 2). A write to index 0 never counts as a bypass.
- Both ports may name the same register; both receive identical data.
- Back-to-back rd_req every cycle is legal: rd_valid stays high and each cycle's operands reflect that cycle's request.
- Read and write on the same edge: the array update and the bypassed latch update both occur. The following read of that index returns the new data from the array.
- All sequential state updates on the rising clk edge only. No combinational path from inputs to outputs.
- Implementation: two-dimensional register array plus two output registers.

Test Plan:
- Reset, then rd_req with ReadReg1=29, ReadReg2=0 -> next edge A_out=227, B_out=0, rd_valid=1, rd_hit_bypass=0.
- Write 0x12345678 to reg 8; next cycle rd_req ReadReg1=8, ReadReg2=8 -> A_out=B_out=0x12345678, rd_hit_bypass=0.
- Same cycle: RegWrite=1, WriteReg=31, WriteData=0xCAFEF00D, rd_req with ReadReg2=31 -> B_out=0xCAFEF00D, rd_hit_bypass=1; a later read of 31 returns 0xCAFEF00D.
- RegWrite=1, WriteReg=0, WriteData=0xFFFFFFFF with a same-cycle read of reg 0 -> A_out=0, rd_hit_bypass=0; later read of reg 0 -> 0.
- rd_req pulse, then two idle cycles -> rd_valid high exactly one cycle; A_out/B_out hold their values.
- Write reg 29 = 0x100, then assert reset mid-cycle (asynchronous) -> A_out/B_out/rd_valid clear immediately; after release, a read of reg 29 returns 227.
